step_seq_ctrl: RTL and testbench

STEP_SEQ_CTRL -- requirements
Module: step_seq_ctrl

---
 rtl/step_seq_pkg.sv | 16 +
 rtl/rr_arb2.sv | 17 +
 rtl/step_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_step_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step sequencer controller.
package step_seq_pkg;

  localparam int STEP_W_DEF = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIN   = 2'd2,
    ABORT = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
module rr_arb2
  import step_seq_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/step_seq_ctrl.sv
// Step sequencer: grants one requester at a time and drives an external up/down counter.
// Optional feedback check of cnt_fb against pos is enabled by STEP_SEQ_FBCHECK_EN.
module step_seq_ctrl
  import step_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        dir,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  input  logic [1:0]        cnt_fb,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              E,
  output logic              x,
  output logic              busy,
  output logic [1:0]        pos,
  output logic              err
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              dir_q, dir_d;
  logic [1:0]        win_q, win_d;
  logic              lastGnt_q, lastGnt_d;
  logic [1:0]        pos_q, pos_d;

  logic [1:0]        arbWin;
  logic [STEP_W-1:0] selSteps;
  logic              selDir;
  logic              reqWin;

  rr_arb2 u_arb (
    .req      (req),
    .last_gnt (lastGnt_q),
    .win      (arbWin)
  );

  assign selSteps = arbWin[0] ? steps0 : steps1;
  assign selDir   = arbWin[0] ? dir[0] : dir[1];
  assign reqWin   = |(req & win_q);

  // A requester withdrawing mid-move wins over a normal finish on the same cycle.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    win_d     = win_q;
    lastGnt_d = lastGnt_q;
    pos_d     = pos_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = arbWin;
          dir_d   = selDir;
          rem_d   = selSteps;
          state_d = (selSteps != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        pos_d = (dir_q == DIR_UP) ? pos_q + 2'd1 : pos_q - 2'd1;
        rem_d = rem_q - STEP_W'(1);
        if (!reqWin) begin
          state_d = ABORT;
        end else if (rem_q == STEP_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        lastGnt_d = win_q[1];
        state_d   = IDLE;
      end
      ABORT: begin
        lastGnt_d = win_q[1];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      win_q     <= 2'b00;
      lastGnt_q <= 1'b1;
      pos_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      win_q     <= win_d;
      lastGnt_q <= lastGnt_d;
      pos_q     <= pos_d;
    end
  end

  assign E    = (state_q == RUN);
  assign x    = E & dir_q;
  assign gnt  = (state_q == RUN || state_q == FIN) ? win_q : 2'b00;
  assign done = (state_q == FIN) ? win_q : 2'b00;
  assign busy = (state_q != IDLE);
  assign pos  = pos_q;

`ifdef STEP_SEQ_FBCHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cnt_fb != pos_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unusedFb;
  assign unusedFb = ^cnt_fb;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl using a scoreboard of expected moves.
module tb_step_seq_ctrl;

  localparam int STEP_W = 4;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [1:0]        dir;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic [1:0]        cnt_fb;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              E;
  logic              x;
  logic              busy;
  logic [1:0]        pos;
  logic              err;

  logic [1:0] cntModel;
  logic       fbCorrupt;

  typedef struct {
    logic [1:0] doneV;
    int         nSteps;
    logic [1:0] posV;
    logic       dirV;
  } expT;

  expT sb[$];

  int         checks;
  int         errors;
  logic [1:0] modelPos;
  logic       modelLast;
  logic [1:0] monPos;
  int         abCnt;
  int         abCyc;

  step_seq_ctrl #(.STEP_W(STEP_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .dir    (dir),
    .steps0 (steps0),
    .steps1 (steps1),
    .cnt_fb (cnt_fb),
    .gnt    (gnt),
    .done   (done),
    .E      (E),
    .x      (x),
    .busy   (busy),
    .pos    (pos),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external 2-bit up/down counter, reset together with the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) cntModel <= 2'b00;
    else if (E) cntModel <= x ? cntModel + 2'd1 : cntModel - 2'd1;
  end

  assign cnt_fb = fbCorrupt ? (cntModel ^ 2'b01) : cntModel;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] pickWinner(input logic [1:0] r, input logic last);
    if (r == 2'b11) return last ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic applyReset();
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    modelPos  = 2'b00;
    modelLast = 1'b1;
    monPos    = 2'b00;
    sb.delete();
  endtask

  // Drives one request pattern, queues the expected moves, then watches the DUT until they all complete.
  task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] dirV,
                               input logic [3:0] s0, input logic [3:0] s1,
                               input int nMoves, input bit scramble);
    logic [1:0] w;
    logic [1:0] p;
    logic       d;
    int         st;
    int         got;
    int         cyc;
    int         eCnt;
    bit         prevE;
    expT        e;
    expT        ex;
    req    = reqV;
    dir    = dirV;
    steps0 = s0;
    steps1 = s1;
    for (int k = 0; k < nMoves; k++) begin
      w  = pickWinner(reqV, modelLast);
      st = w[0] ? int'(s0) : int'(s1);
      d  = w[0] ? dirV[0] : dirV[1];
      p  = modelPos;
      for (int j = 0; j < st; j++) p = d ? p + 2'd1 : p - 2'd1;
      e.doneV  = w;
      e.nSteps = st;
      e.posV   = p;
      e.dirV   = d;
      sb.push_back(e);
      modelLast = w[1];
      modelPos  = p;
    end
    got   = 0;
    cyc   = 0;
    eCnt  = 0;
    prevE = 1'b0;
    while (got < nMoves && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (E && sb.size() > 0) begin
        checkOutput("xDir", int'(x), int'(sb[0].dirV));
        checkOutput("posStep", int'(pos), int'(monPos));
        checkOutput("gntRun", int'(gnt), int'(sb[0].doneV));
        monPos = sb[0].dirV ? monPos + 2'd1 : monPos - 2'd1;
        eCnt++;
        if (scramble && eCnt == 1) begin
          dir    = ~dir;
          steps0 = 4'($urandom);
          steps1 = 4'($urandom);
        end
      end
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousDone", int'(done), 0);
        end else begin
          ex = sb.pop_front();
          checkOutput("doneVal", int'(done), int'(ex.doneV));
          checkOutput("gntFin", int'(gnt), int'(ex.doneV));
          checkOutput("eCount", eCnt, ex.nSteps);
          checkOutput("posEnd", int'(pos), int'(ex.posV));
          checkOutput("doneLat", int'(prevE), (ex.nSteps > 0) ? 1 : 0);
          checkOutput("eInFin", int'(E), 0);
          eCnt = 0;
          got++;
          if (got == nMoves) req = 2'b00;
        end
      end
      prevE = E;
    end
    checkOutput("timeout", got, nMoves);
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busyIdle", int'(busy), 0);
    checkOutput("errClean", int'(err), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    fbCorrupt = 1'b0;
    req       = 2'b00;
    dir       = 2'b00;
    steps0    = '0;
    steps1    = '0;
    reset     = 1'b1;
    modelPos  = 2'b00;
    modelLast = 1'b1;
    monPos    = 2'b00;
    #2;
    checkOutput("resetState", int'({gnt, done, E, x, busy, pos, err}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Up move of 3 steps from position 0.
    applyStimulus(2'b01, 2'b01, 4'd3, 4'd0, 1, 1'b0);

    // Down move of 2 steps from 0 wraps through 3.
    applyReset();
    applyStimulus(2'b10, 2'b00, 4'd0, 4'd2, 1, 1'b0);

    // Held tie right after reset alternates 0,1,0,1.
    applyReset();
    applyStimulus(2'b11, 2'b11, 4'd1, 4'd1, 4, 1'b0);

    // Zero-step move: immediate done, no enable.
    applyStimulus(2'b01, 2'b01, 4'd0, 4'd0, 1, 1'b0);

    // Maximum move, with inputs scrambled while running.
    applyStimulus(2'b10, 2'b10, 4'd7, 4'd15, 1, 1'b1);
    applyStimulus(2'b01, 2'b00, 4'd2, 4'd9, 1, 1'b1);

    // Withdraw request after two enable cycles.
    req    = 2'b01;
    dir    = 2'b01;
    steps0 = 4'd5;
    steps1 = 4'd0;
    abCnt  = 0;
    abCyc  = 0;
    while (abCnt < 2 && abCyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      abCyc++;
      if (E) abCnt++;
    end
    checkOutput("abortSetup", abCnt, 2);
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortE", int'(E), 0);
    checkOutput("abortGnt", int'(gnt), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortBusy", int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortIdle", int'(busy), 0);
    checkOutput("abortNoDone", int'(done), 0);
    modelPos  = modelPos + 2'd2;
    modelLast = 1'b0;
    monPos    = modelPos;
    checkOutput("abortPos", int'(pos), int'(modelPos));

    // Aborted requester 0 counts as last grant, so requester 1 wins this tie.
    applyStimulus(2'b11, 2'b11, 4'd1, 4'd1, 1, 1'b0);

    // Reset asserted mid-move clears outputs without waiting for a clock.
    req    = 2'b01;
    dir    = 2'b01;
    steps0 = 4'd5;
    @(posedge clk);
    @(negedge clk);
    checkOutput("preResetE", int'(E), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRst", int'({gnt, done, E, x, busy, pos, err}), 0);
    req = 2'b00;
    @(negedge clk);
    reset     = 1'b0;
    modelPos  = 2'b00;
    modelLast = 1'b1;
    monPos    = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checkOutput("postRstDone", int'(done), 0);
    checkOutput("postRstBusy", int'(busy), 0);

    // Feedback corruption for a single cycle.
    applyReset();
    @(negedge clk);
    fbCorrupt = 1'b1;
    @(negedge clk);
    fbCorrupt = 1'b0;
`ifdef STEP_SEQ_FBCHECK_EN
    checkOutput("errSet", int'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("errSticky", int'(err), 1);
`else
    checkOutput("errTied", int'(err), 0);
    repeat (3) @(negedge clk);
    checkOutput("errTiedLater", int'(err), 0);
`endif
    applyReset();
    checkOutput("errCleared", int'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
